// File: rtl/mux_n_arbitrado.sv
// N-channel multiplexer with fixed-select or round-robin arbitration feeding a
// single registered output stage with a valid/ready handshake.
module mux_n_arbitrado #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N*WIDTH-1:0]   entrada,
    input  logic [N-1:0]         entrada_valida,
    output logic [N-1:0]         entrada_pronta,
    input  logic [SELW-1:0]      controle,
    input  logic                 modo,
    output logic [WIDTH-1:0]     saida,
    output logic                 saida_valida,
    input  logic                 saida_pronta,
    output logic [SELW-1:0]      canal_saida
);

    if (int'(SELW) < $clog2(N) || N < 2) begin : gen_param_check
        $error("mux_n_arbitrado: SELW=%0d too small for N=%0d", SELW, N);
    end

    logic [WIDTH-1:0] saida_q, saida_d;
    logic             valida_q, valida_d;
    logic [SELW-1:0]  canal_q, canal_d;
    logic [SELW-1:0]  ultimo_q, ultimo_d;

    logic             livre;
    logic             grant_fix, grant_rr, grant;
    logic [SELW-1:0]  idx_fix, idx_rr, idx_hi, idx_any, g;
    logic             any_hi, any_all;
    logic [N-1:0]     mask_hi, valid_hi;
    logic [WIDTH-1:0] dado;

    // A new word may enter in the same cycle the held one drains.
    assign livre = !valida_q || saida_pronta;

    // Fixed mode: out-of-range selects never match any channel.
    always_comb begin
        grant_fix = 1'b0;
        idx_fix   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (controle == SELW'(i) && entrada_valida[i]) begin
                grant_fix = 1'b1;
                idx_fix   = SELW'(i);
            end
        end
    end

    // Round-robin: prefer the lowest valid channel above ultimo, else wrap to the lowest.
    always_comb begin
        mask_hi = '0;
        for (int i = 0; i < int'(N); i++) begin
            mask_hi[i] = (i > int'(ultimo_q));
        end
    end

    assign valid_hi = entrada_valida & mask_hi;

    always_comb begin
        any_hi  = 1'b0;
        any_all = 1'b0;
        idx_hi  = '0;
        idx_any = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (valid_hi[i]) begin
                any_hi = 1'b1;
                idx_hi = SELW'(i);
            end
            if (entrada_valida[i]) begin
                any_all = 1'b1;
                idx_any = SELW'(i);
            end
        end
    end

    always_comb begin
        grant_rr = any_all;
        idx_rr   = any_hi ? idx_hi : idx_any;
    end

    always_comb begin
        grant = 1'b0;
        g     = '0;
        if (!Reset && livre) begin
            grant = modo ? grant_rr : grant_fix;
            g     = modo ? idx_rr : idx_fix;
        end
    end

    always_comb begin
        entrada_pronta = '0;
        dado           = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (g == SELW'(i)) begin
                entrada_pronta[i] = grant;
                dado              = entrada[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        saida_d  = saida_q;
        valida_d = valida_q;
        canal_d  = canal_q;
        ultimo_d = ultimo_q;
        if (grant) begin
            saida_d  = dado;
            canal_d  = g;
            valida_d = 1'b1;
            if (modo) begin
                ultimo_d = g;
            end
        end else if (valida_q && saida_pronta) begin
            valida_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            saida_q  <= '0;
            valida_q <= 1'b0;
            canal_q  <= '0;
            ultimo_q <= SELW'(N - 1);
        end else begin
            saida_q  <= saida_d;
            valida_q <= valida_d;
            canal_q  <= canal_d;
            ultimo_q <= ultimo_d;
        end
    end

    assign saida        = saida_q;
    assign saida_valida = valida_q;
    assign canal_saida  = canal_q;

endmodule

// File: tb/tb_mux_n_arbitrado.sv
// Directed bench for mux_n_arbitrado: a 4-channel instance plus a 3-channel
// instance for the out-of-range select case.
module tb_mux_n_arbitrado;

    logic           Clock;
    logic           Reset;
    logic [127:0]   entrada;
    logic [3:0]     entrada_valida;
    logic [3:0]     entrada_pronta;
    logic [1:0]     controle;
    logic           modo;
    logic [31:0]    saida;
    logic           saida_valida;
    logic           saida_pronta;
    logic [1:0]     canal_saida;

    logic [95:0]    e3;
    logic [2:0]     v3;
    logic [2:0]     p3;
    logic [1:0]     ctl3;
    logic           modo3;
    logic [31:0]    saida3;
    logic           sv3;
    logic           sp3;
    logic [1:0]     canal3;

    int vectors = 0;
    int errors  = 0;

    mux_n_arbitrado #(.WIDTH(32), .N(4), .SELW(2)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .entrada        (entrada),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .controle       (controle),
        .modo           (modo),
        .saida          (saida),
        .saida_valida   (saida_valida),
        .saida_pronta   (saida_pronta),
        .canal_saida    (canal_saida)
    );

    mux_n_arbitrado #(.WIDTH(32), .N(3), .SELW(2)) dut3 (
        .Clock          (Clock),
        .Reset          (Reset),
        .entrada        (e3),
        .entrada_valida (v3),
        .entrada_pronta (p3),
        .controle       (ctl3),
        .modo           (modo3),
        .saida          (saida3),
        .saida_valida   (sv3),
        .saida_pronta   (sp3),
        .canal_saida    (canal3)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset          = 1'b1;
        entrada_valida = 4'b1111;
        modo           = 1'b1;
        saida_pronta   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            vectors++;
            if (entrada_pronta !== 4'b0000) begin
                errors++;
                $display("FAIL reset_pronta cycle %0d: got %b want 0000", c, entrada_pronta);
            end
            tick();
        end
        vectors++;
        if (saida !== 32'h0 || saida_valida !== 1'b0 || canal_saida !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: saida=%h valida=%b canal=%0d want 0/0/0",
                     saida, saida_valida, canal_saida);
        end
        entrada_valida = 4'b0000;
        Reset          = 1'b0;
        settle();
    endtask

    task automatic test_fixed();
        modo           = 1'b0;
        controle       = 2'd2;
        entrada_valida = 4'b0100;
        saida_pronta   = 1'b1;
        settle();
        vectors++;
        if (entrada_pronta !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_pronta: got %b want 0100", entrada_pronta);
        end
        tick();
        entrada_valida = 4'b0000;
        settle();
        vectors++;
        if (saida !== 32'hA5A50002 || canal_saida !== 2'd2 || saida_valida !== 1'b1) begin
            errors++;
            $display("FAIL fixed_out: saida=%h canal=%0d valida=%b want a5a50002/2/1",
                     saida, canal_saida, saida_valida);
        end
        vectors++;
        if (entrada_pronta !== 4'b0000) begin
            errors++;
            $display("FAIL fixed_pronta_idle: got %b want 0000", entrada_pronta);
        end
        tick();
        vectors++;
        if (saida_valida !== 1'b0 || saida !== 32'hA5A50002) begin
            errors++;
            $display("FAIL fixed_drain: valida=%b saida=%h want 0/a5a50002",
                     saida_valida, saida);
        end
    endtask

    task automatic test_backpressure();
        entrada[32 +: 32] = 32'h0000BEEF;
        modo              = 1'b0;
        controle          = 2'd1;
        entrada_valida    = 4'b0010;
        saida_pronta      = 1'b1;
        tick();
        saida_pronta   = 1'b0;
        entrada_valida = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            settle();
            vectors++;
            if (entrada_pronta !== 4'b0000 || saida !== 32'h0000BEEF || saida_valida !== 1'b1) begin
                errors++;
                $display("FAIL backpressure cycle %0d: pronta=%b saida=%h valida=%b want 0000/0000beef/1",
                         c, entrada_pronta, saida, saida_valida);
            end
            tick();
        end
        entrada[32 +: 32] = 32'h0000CAFE;
        saida_pronta      = 1'b1;
        settle();
        vectors++;
        if (entrada_pronta !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_pronta: got %b want 0010", entrada_pronta);
        end
        tick();
        vectors++;
        if (saida !== 32'h0000CAFE || saida_valida !== 1'b1 || canal_saida !== 2'd1) begin
            errors++;
            $display("FAIL bp_refill: saida=%h valida=%b canal=%0d want 0000cafe/1/1",
                     saida, saida_valida, canal_saida);
        end
        entrada_valida    = 4'b0000;
        entrada[32 +: 32] = 32'hA5A50001;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] seq_all [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [1:0] seq_odd [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        logic [31:0] want;
        do_reset();
        modo           = 1'b1;
        entrada_valida = 4'b1111;
        saida_pronta   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            want = 32'hA5A50000 | 32'(seq_all[c]);
            vectors++;
            if (canal_saida !== seq_all[c] || saida_valida !== 1'b1 || saida !== want) begin
                errors++;
                $display("FAIL rr_all step %0d: canal=%0d valida=%b saida=%h want %0d/1/%h",
                         c, canal_saida, saida_valida, saida, seq_all[c], want);
            end
        end
        entrada_valida = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (canal_saida !== seq_odd[c] || saida_valida !== 1'b1) begin
                errors++;
                $display("FAIL rr_odd step %0d: canal=%0d valida=%b want %0d/1",
                         c, canal_saida, saida_valida, seq_odd[c]);
            end
        end
        entrada_valida = 4'b0000;
        tick();
    endtask

    task automatic test_out_of_range();
        do_reset();
        modo3 = 1'b0;
        ctl3  = 2'd0;
        v3    = 3'b001;
        sp3   = 1'b1;
        settle();
        vectors++;
        if (p3 !== 3'b001) begin
            errors++;
            $display("FAIL oor_load_pronta: got %b want 001", p3);
        end
        tick();
        ctl3 = 2'd3;
        v3   = 3'b111;
        settle();
        vectors++;
        if (p3 !== 3'b000 || sv3 !== 1'b1) begin
            errors++;
            $display("FAIL oor_no_grant: pronta=%b valida=%b want 000/1", p3, sv3);
        end
        tick();
        vectors++;
        if (sv3 !== 1'b0 || saida3 !== 32'h33330000 || canal3 !== 2'd0) begin
            errors++;
            $display("FAIL oor_drain: valida=%b saida=%h canal=%0d want 0/33330000/0",
                     sv3, saida3, canal3);
        end
        v3 = 3'b000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        modo           = 1'b1;
        entrada_valida = 4'b1111;
        saida_pronta   = 1'b1;
        tick();
        tick();
        vectors++;
        if (canal_saida !== 2'd1 || saida_valida !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: canal=%0d valida=%b want 1/1", canal_saida, saida_valida);
        end
        Reset = 1'b1;
        settle();
        vectors++;
        if (entrada_pronta !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_pronta: got %b want 0000", entrada_pronta);
        end
        tick();
        vectors++;
        if (saida_valida !== 1'b0 || saida !== 32'h0 || canal_saida !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_state: valida=%b saida=%h canal=%0d want 0/0/0",
                     saida_valida, saida, canal_saida);
        end
        Reset = 1'b0;
        settle();
        vectors++;
        if (entrada_pronta !== 4'b0001) begin
            errors++;
            $display("FAIL mid_release_pronta: got %b want 0001", entrada_pronta);
        end
        tick();
        vectors++;
        if (canal_saida !== 2'd0 || saida_valida !== 1'b1 || saida !== 32'hA5A50000) begin
            errors++;
            $display("FAIL mid_first_grant: canal=%0d valida=%b saida=%h want 0/1/a5a50000",
                     canal_saida, saida_valida, saida);
        end
        entrada_valida = 4'b0000;
    endtask

    initial begin
        Reset          = 1'b1;
        entrada        = {32'hA5A50003, 32'hA5A50002, 32'hA5A50001, 32'hA5A50000};
        entrada_valida = 4'b0000;
        controle       = 2'd0;
        modo           = 1'b0;
        saida_pronta   = 1'b0;
        e3             = {32'h33330002, 32'h33330001, 32'h33330000};
        v3             = 3'b000;
        ctl3           = 2'd0;
        modo3          = 1'b0;
        sp3            = 1'b1;

        test_reset();
        test_fixed();
        test_backpressure();
        test_round_robin();
        test_out_of_range();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mux_n_arbitrado.md
Name: mux_n_arbitrado

Overview:
- Parametrised successor to the team's 32-bit 2:1 combinational multiplexer.
- Selects one of N input channels of WIDTH bits and delivers it through a single registered output stage with a valid/ready handshake.
- Two selection modes: fixed select driven by `controle`, or round-robin arbitration among the requesting channels.
- Sits between multiple datapath sources and a single downstream consumer that may apply backpressure.

Parameters:
- WIDTH, 32: data width per channel.
- N, 4: number of input channels, N >= 2.
- SELW, 2: select and channel-index width. Must equal ceil(log2(N)), minimum 1.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- entrada  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- entrada_valida  input  N  per-channel request/valid.
- entrada_pronta  output  N  per-channel accept strobe, one-hot or zero.
- controle  input  SELW  channel select, used in fixed mode.
- modo  input  1  0 = fixed select, 1 = round-robin.
- saida  output  WIDTH  registered output data.
- saida_valida  output  1  output register holds a word.
- saida_pronta  input  1  consumer ready.
- canal_saida  output  SELW  index of the channel that sourced `saida`.

Behaviour:
- Reset (Reset=1 at a rising edge):
  - saida=0, saida_valida=0, canal_saida=0.
  - Round-robin pointer `ultimo` = N-1.
  - entrada_pronta=0 while Reset is high.
  - Reset asserted mid-transfer discards the held word; no handshake completes on that edge.
- Slot availability: `livre` = !saida_valida | saida_pronta.
  - The register may accept a new word in the same cycle the current one drains.
  - Sustained throughput is 1 word/cycle.
- Grant, combinational, computed only when livre=1 and Reset=0:
  - Fixed mode (modo=0): grant channel `controle` if controle < N and entrada_valida[controle]=1. Otherwise no grant. Other channels are ignored.
  - Round-robin mode (modo=1): grant the first i with entrada_valida[i]=1, searching ultimo+1, ultimo+2, … modulo N and wrapping. No grant if no channel is valid.
- entrada_pronta[g]=1 only for the granted channel g, in the cycle of the grant; all other bits are 0.
  - A transfer on channel i completes when entrada_valida[i] & entrada_pronta[i] at the rising edge.
- On a grant (rising edge):
  - saida <= entrada[g], canal_saida <= g, saida_valida <= 1.
  - In round-robin mode only, ultimo <= g.
- No grant but a drain (saida_valida & saida_pronta): saida_valida <= 0. saida and canal_saida hold their last values.
- Latency: an input accepted at edge k is visible on saida after edge k; 1 cycle.
- Backpressure (saida_valida=1, saida_pronta=0):
  - saida, canal_saida and saida_valida remain stable.
  - entrada_pronta = 0 for all channels.
- Mode changes take effect on the next grant decision. Fixed mode never modifies `ultimo`.
- Input-side rule: entrada_valida may deassert without a transfer; there is no stickiness requirement.
- No combinational path from saida_pronta to saida or saida_valida.
  - A path from saida_pronta to entrada_pronta is permitted.
- Parameter check: if SELW < ceil(log2(N)), simulation reports an error at time 0.

Test Plan:
- Reset: hold Reset=1 for 2 cycles with all inputs valid → saida=0, saida_valida=0, canal_saida=0, entrada_pronta=4'b0000.
- Fixed select: N=4, modo=0, controle=2, entrada[2]=32'hA5A50002, only channel 2 valid, saida_pronta=1 → entrada_pronta=4'b0100 for one cycle. Next cycle: saida=32'hA5A50002, canal_saida=2, saida_valida=1.
- Backpressure: output holding 32'h0000BEEF, saida_pronta=0 for 3 cycles, all channels valid → saida stays 32'h0000BEEF, entrada_pronta=0 all 3 cycles. Raising saida_pronta gives drain and refill on the same edge.
- Round-robin: modo=1 after reset, all 4 channels valid, saida_pronta=1 → canal_saida sequence 0,1,2,3,0, one word per cycle. With only channels 1 and 3 valid → 1,3,1,3.
- Out-of-range select: N=3, SELW=2, modo=0, controle=3, all valid → no grant, entrada_pronta=3'b000, saida_valida drops after drain.
- Reset mid-operation: round-robin running with ultimo=1, output valid; assert Reset one cycle → saida_valida=0. First grant after release goes to channel 0, not 2.
